// File: rtl/traceback_controller.sv
// traceback_controller: walks the NW arrow matrix from (len_a,len_b) to (0,0), issuing reads and datapath strobes
module traceback_controller #(
  parameter int N     = 128,
  parameter int IDX_W = $clog2(N + 1),
  parameter int LEN_W = $clog2(2 * N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] len_a,
  input  logic [IDX_W-1:0] len_b,
  input  logic [2:0]       dir_rd_data,
  output logic             dir_rd_en,
  output logic [IDX_W-1:0] dir_i,
  output logic [IDX_W-1:0] dir_j,
  output logic [IDX_W-1:0] seqa_addr,
  output logic [IDX_W-1:0] seqb_addr,
  output logic             en_traceB,
  output logic [2:0]       symbol,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] aligned_len
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_DONE, S_ERR} state_t;
  state_t           state_q;
  logic [IDX_W-1:0] i_q, j_q, i_d, j_d, ri, rj;
  logic [IDX_W-1:0] dir_i_q, dir_j_q, seqa_q, seqb_q;
  logic [LEN_W-1:0] aligned_len_q;
  logic [2:0]       arrow, symbol_q;
  logic             arrow_ok, oversize, load_rd;
  logic             dir_rd_en_q, en_traceB_q, busy_q, done_q, err_q;
  // Resolve the arrow (boundary cells are forced) and the cell the next read targets
  always_comb begin
    arrow    = i_q == '0 ? 3'b100 : j_q == '0 ? 3'b010 : dir_rd_data;
    arrow_ok = arrow inside {3'b001, 3'b010, 3'b100};
    i_d      = i_q - IDX_W'(arrow[0] | arrow[1]);
    j_d      = j_q - IDX_W'(arrow[0] | arrow[2]);
    oversize = len_a > IDX_W'(N) || len_b > IDX_W'(N);
    ri       = state_q == S_IDLE ? len_a : i_d;
    rj       = state_q == S_IDLE ? len_b : j_d;
    load_rd  = state_q == S_IDLE ? start && !oversize && (len_a != '0 || len_b != '0)
                                 : state_q == S_EVAL && arrow_ok && (i_d != '0 || j_d != '0);
  end
  // Walk FSM; read address/strobe are loaded on entry to READ so memory data lands in EVAL
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      i_q           <= '0;
      j_q           <= '0;
      dir_rd_en_q   <= 1'b0;
      dir_i_q       <= '0;
      dir_j_q       <= '0;
      seqa_q        <= '0;
      seqb_q        <= '0;
      en_traceB_q   <= 1'b0;
      symbol_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      aligned_len_q <= '0;
    end else begin
      dir_rd_en_q <= 1'b0;
      en_traceB_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          i_q           <= len_a;
          j_q           <= len_b;
          aligned_len_q <= '0;
          err_q         <= oversize;
          busy_q        <= 1'b1;
          state_q       <= oversize ? S_ERR : load_rd ? S_READ : S_DONE;
        end
        S_READ: state_q <= S_EVAL;
        S_EVAL: if (!arrow_ok) begin
          err_q   <= 1'b1;
          state_q <= S_ERR;
        end else begin
          en_traceB_q   <= 1'b1;
          symbol_q      <= arrow;
          i_q           <= i_d;
          j_q           <= j_d;
          aligned_len_q <= aligned_len_q + LEN_W'(1);
          state_q       <= load_rd ? S_READ : S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (load_rd) begin
        dir_rd_en_q <= ri != '0 && rj != '0;
        dir_i_q     <= ri;
        dir_j_q     <= rj;
        seqa_q      <= ri == '0 ? '0 : ri - IDX_W'(1);
        seqb_q      <= rj == '0 ? '0 : rj - IDX_W'(1);
      end
    end
  end
  assign dir_rd_en   = dir_rd_en_q;
  assign dir_i       = dir_i_q;
  assign dir_j       = dir_j_q;
  assign seqa_addr   = seqa_q;
  assign seqb_addr   = seqb_q;
  assign en_traceB   = en_traceB_q;
  assign symbol      = symbol_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign aligned_len = aligned_len_q;
endmodule

// File: tb/tb_traceback_controller.sv
// tb_traceback_controller: scoreboard bench with a reference walk over a synchronous arrow memory
module tb_traceback_controller;
  localparam int N     = 128;
  localparam int IDX_W = $clog2(N + 1);
  localparam int LEN_W = $clog2(2 * N + 1);
  logic             clk = 0, rst = 1, start = 0;
  logic [IDX_W-1:0] len_a = '0, len_b = '0;
  logic [2:0]       dir_rd_data = '0;
  logic             dir_rd_en, en_traceB, busy, done, err;
  logic [IDX_W-1:0] dir_i, dir_j, seqa_addr, seqb_addr;
  logic [2:0]       symbol;
  logic [LEN_W-1:0] aligned_len;
  logic [2:0]       mem [0:N][0:N];
  logic [2:0]       sym_q [$];
  int               rd_q [$];
  int               n_vec = 0, n_err = 0, exp_steps, exp_end;
  bit               exp_err;

  traceback_controller #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .len_a(len_a), .len_b(len_b),
    .dir_rd_data(dir_rd_data), .dir_rd_en(dir_rd_en), .dir_i(dir_i), .dir_j(dir_j),
    .seqa_addr(seqa_addr), .seqb_addr(seqb_addr), .en_traceB(en_traceB), .symbol(symbol),
    .busy(busy), .done(done), .err(err), .aligned_len(aligned_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dir_rd_en) dir_rd_data <= mem[dir_i][dir_j];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (en_traceB) begin
      e = sym_q.size() > 0 ? int'(sym_q.pop_front()) : -1;
      chk("symbol", 64'(symbol), 64'(e));
    end
    if (dir_rd_en) begin
      e = rd_q.size() > 0 ? rd_q.pop_front() : -1;
      chk("rd_ij", 64'({dir_i, dir_j}), 64'(e));
      chk("seqa", 64'(seqa_addr), 64'(e[15:8] - 1));
      chk("seqb", 64'(seqb_addr), 64'(e[7:0] - 1));
    end
  end

  task automatic fill(input int mode);
    for (int a = 0; a <= N; a++)
      for (int b = 0; b <= N; b++)
        mem[a][b] = mode == 0 ? 3'(1 << $urandom_range(0, 2)) : 3'(mode);
  endtask

  task automatic launch(input int la, input int lb);
    int i = la, j = lb;
    logic [2:0] a;
    exp_steps = 0;
    exp_err   = la > N || lb > N;
    if (!exp_err)
      while (i != 0 || j != 0) begin
        if (i == 0) a = 3'b100;
        else if (j == 0) a = 3'b010;
        else begin
          a = mem[i][j];
          rd_q.push_back((i << 8) | j);
        end
        if (!(a == 3'b001 || a == 3'b010 || a == 3'b100)) begin
          exp_err = 1;
          break;
        end
        sym_q.push_back(a);
        if (a != 3'b100) i--;
        if (a != 3'b010) j--;
        exp_steps++;
      end
    exp_end = (la > N || lb > N) ? 2 : exp_err ? 2 * exp_steps + 4 : 2 * exp_steps + 2;
    @(negedge clk);
    start = 1;
    len_a = IDX_W'(la);
    len_b = IDX_W'(lb);
    @(negedge clk);
    start = 0;
  endtask

  task automatic run(input int la, input int lb, input bit poke);
    int cyc = 1, nd = 0;
    launch(la, lb);
    chk("busy_start", 64'(busy), 64'(1));
    while (busy && cyc < 1000) begin
      if (poke) begin
        start = cyc == 3;
        len_a = 1;
        len_b = 1;
      end
      @(negedge clk);
      cyc++;
      if (done) nd++;
    end
    start = 0;
    chk("end_cycle", 64'(cyc), 64'(exp_end));
    chk("done_cnt", 64'(nd), 64'(!exp_err));
    chk("err", 64'(err), 64'(exp_err));
    chk("aligned_len", 64'(aligned_len), 64'(exp_steps));
    chk("sym_left", 64'(sym_q.size()), 64'(0));
    chk("rd_left", 64'(rd_q.size()), 64'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", {dir_rd_en, dir_i, dir_j, seqa_addr, seqb_addr, en_traceB, symbol, busy, done, err, aligned_len}, 64'(0));
    rst = 0;
    fill(1);
    run(3, 3, 0);
    mem[2][4] = 3'b100;
    mem[2][3] = 3'b001;
    mem[1][2] = 3'b001;
    run(2, 4, 0);
    run(0, 0, 0);
    run(0, 3, 0);
    fill(1);
    mem[1][1] = 3'b000;
    run(2, 2, 0);
    mem[2][2] = 3'b011;
    run(2, 2, 0);
    run(N + 1, 2, 0);
    fill(0);
    run(N, N, 0);
    run(5, 4, 1);
    run(7, 2, 0);
    fill(1);
    launch(3, 3);
    repeat (4) @(negedge clk);
    rst   = 1;
    start = 1;
    len_a = 2;
    len_b = 2;
    @(negedge clk);
    rst   = 0;
    start = 0;
    chk("rst_outs", {dir_rd_en, dir_i, dir_j, seqa_addr, seqb_addr, en_traceB, symbol, busy, done, err, aligned_len}, 64'(0));
    sym_q.delete();
    rd_q.delete();
    run(3, 3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/traceback_controller.md
Name: traceback_controller

Overview:
- Sequences the traceback phase of the NW aligner.
- Walks the direction (arrow) matrix from cell (len_a, len_b) back to (0,0), issuing direction-memory and sequence-memory read addresses each step.
- Feeds each resolved arrow to the traceback datapath, pulsing its en_traceB strobe once per step.
- Reports completion, alignment length and malformed-matrix errors to the top-level control.

Parameters:
- N, 128, maximum sequence length per input.
- IDX_W, $clog2(N+1), width of row/column indices 0..N.
- LEN_W, $clog2(2*N+1), width of the alignment step counter (max 2N).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin traceback; ignored unless FSM is IDLE
- len_a  in  IDX_W  length of sequence A (matrix rows), sampled on accepted start
- len_b  in  IDX_W  length of sequence B (matrix columns), sampled on accepted start
- dir_rd_data  in  3  arrow from direction memory, valid 1 cycle after dir_rd_en
- dir_rd_en  out  1  direction-memory read strobe
- dir_i  out  IDX_W  direction-memory row address
- dir_j  out  IDX_W  direction-memory column address
- seqa_addr  out  IDX_W  sequence-A memory address (i-1), data expected 1 cycle later
- seqb_addr  out  IDX_W  sequence-B memory address (j-1), data expected 1 cycle later
- en_traceB  out  1  one-cycle datapath enable per traceback step
- symbol  out  3  arrow presented to the datapath, qualified by en_traceB
- busy  out  1  high from accepted start until DONE/ERR exits
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error flag
- aligned_len  out  LEN_W  number of steps taken; stable after done

Behaviour:
- Reset: synchronous on rst=1 at the clk edge, including mid-walk. FSM goes to IDLE. All outputs go to 0: dir_rd_en, dir_i, dir_j, seqa_addr, seqb_addr, en_traceB, symbol, busy, done, err, aligned_len. Internal i, j and step counter also clear.
- Arrow encoding: 3'b001 diagonal (i-1, j-1); 3'b010 up (i-1); 3'b100 left (j-1). Any other code is invalid.
- FSM states:
  - IDLE: on start, latch i=len_a, j=len_b. Clear aligned_len and err. Set busy=1.
    - If len_a>N or len_b>N, go to ERR.
    - Else if i==0 and j==0, go to DONE.
    - Else go to READ.
  - READ (1 cycle): drive dir_i=i, dir_j=j, seqa_addr=i-1, seqb_addr=j-1 (clamp to 0 when index is 0).
    - dir_rd_en=1 only when i>0 and j>0. Boundary cells are not read.
    - Go to EVAL.
  - EVAL (1 cycle): resolve the arrow.
    - i==0 forces 3'b100. j==0 forces 3'b010.
    - Otherwise use dir_rd_data. If it is invalid, set err=1 and go to ERR without asserting en_traceB.
    - For a valid arrow: en_traceB=1, symbol=arrow, update i/j per arrow, aligned_len+1.
    - Next state is DONE if the updated i==0 and j==0, else READ.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
  - ERR (1 cycle): busy=0, then IDLE. err stays high until the next accepted start or rst.
- Throughput: 2 cycles per step. Total cycles from start to done pulse = 1 + 2*aligned_len + 1.
- symbol holds its last value when en_traceB=0. The datapath must qualify symbol with en_traceB.
- aligned_len range: max(len_a, len_b) to len_a+len_b. It never exceeds 2N. A counter reaching 2N without reaching (0,0) is impossible by construction and needs no check.
- start while busy is ignored. start asserted in the DONE/ERR cycle is ignored. start asserted together with rst: rst wins.
- i and j never underflow. A boundary force always moves toward 0 along the non-zero axis.

Test Plan:
- len_a=3, len_b=3, matrix all 3'b001 -> 3 en_traceB pulses with symbol 001, (i,j) visited (3,3),(2,2),(1,1); aligned_len=3; done pulses exactly 8 cycles after start.
- len_a=2, len_b=4, arrows: (2,4)=100, (2,3)=001, (1,2)=001, then j=1 row 0 -> forced 100 at (0,1) -> symbols 100,001,001,100; aligned_len=4; dir_rd_en never high when i or j is 0.
- len_a=0, len_b=0 -> no en_traceB, no dir_rd_en, done one cycle after start's DONE entry, aligned_len=0. Separately, len_a=0, len_b=3 -> three forced 100 steps, zero memory reads.
- Interior cell returns 3'b000 or 3'b011 -> err=1, no en_traceB that cycle, busy drops, done never pulses; the next start clears err.
- Overlength len_a=N+1 -> ERR directly, err=1, no reads. start pulses during an active walk are ignored (step sequence unchanged).
- Assert rst mid-walk (after 2 steps) -> next cycle all outputs 0, FSM IDLE; a subsequent start runs a full correct walk.
